// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer between the ALU and the memory stage,
// with registered conditional-branch redirect and head-entry forwarding outputs.
module ex_mem_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_res,
    input  logic            in_zero,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [REGW-1:0] in_rd,
    input  logic [3:0]      in_ctrl,
    input  logic            in_branch,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [XLEN-1:0] out_store_data,
    output logic [REGW-1:0] out_rd,
    output logic [3:0]      out_ctrl,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] store_data;
        logic [REGW-1:0] rd;
        logic [3:0]      ctrl;
    } entry_t;

    count_e          count_q, count_d;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;
    logic            branch_taken_q, branch_taken_d;
    logic [XLEN-1:0] branch_target_q, branch_target_d;

    entry_t          in_entry;
    logic [XLEN-1:0] imm_x2;
    logic            accept;
    logic            pop;

    assign in_entry = '{res: in_res, store_data: in_store_data, rd: in_rd, ctrl: in_ctrl};
    // Branch offset is in halfwords; the shift drops the top bit and the add wraps.
    assign imm_x2   = in_imm << 1;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;

        if (flush) begin
            count_d = EMPTY;
        end else begin
            unique case (count_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        count_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        tail_d  = in_entry;
                        count_d = FULL;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = ONE;
                    end
                end
                default: count_d = EMPTY;
            endcase

            if (accept && in_branch && in_zero) begin
                branch_taken_d  = 1'b1;
                branch_target_d = in_pc + imm_x2;
            end
        end
    end

    // NOTE: payload registers are reset too, because the head outputs must read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q         <= EMPTY;
            head_q          <= '0;
            tail_q          <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            count_q         <= count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign out_res        = head_q.res;
    assign out_store_data = head_q.store_data;
    assign out_rd         = head_q.rd;
    assign out_ctrl       = head_q.ctrl;
    assign branch_taken   = branch_taken_q;
    assign branch_target  = branch_target_q;

    assign fwd_valid = out_valid & head_q.ctrl[3] & (head_q.rd != '0);
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.res;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each task drives one scenario and compares
// outputs against hand-computed values one time unit after the rising edge.
module tb_ex_mem_stage;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_res;
    logic            in_zero;
    logic [XLEN-1:0] in_store_data;
    logic [REGW-1:0] in_rd;
    logic [3:0]      in_ctrl;
    logic            in_branch;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [XLEN-1:0] out_store_data;
    logic [REGW-1:0] out_rd;
    logic [3:0]      out_ctrl;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            fwd_valid;
    logic [REGW-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_data;

    int vectors    = 0;
    int miscompares = 0;

    ex_mem_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_res         (in_res),
        .in_zero        (in_zero),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_ctrl        (in_ctrl),
        .in_branch      (in_branch),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_res        (out_res),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_ctrl       (out_ctrl),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_res        = '0;
        in_zero       = 1'b0;
        in_store_data = '0;
        in_rd         = '0;
        in_ctrl       = 4'b0000;
        in_branch     = 1'b0;
        in_pc         = '0;
        in_imm        = '0;
        flush         = 1'b0;
    endtask

    task automatic send(input logic [XLEN-1:0] res, input logic [REGW-1:0] rd,
                        input logic [3:0] ctrl);
        in_valid  = 1'b1;
        in_res    = res;
        in_rd     = rd;
        in_ctrl   = ctrl;
        in_branch = 1'b0;
        in_zero   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++;
        if (branch_taken !== 1'b0 || fwd_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_bt_fwd got=%b/%b exp=0/0", branch_taken, fwd_valid);
        end
        vectors++;
        if (out_res !== 64'h0 || branch_target !== 64'h0) begin
            miscompares++; $display("FAIL reset_zero_payload res=%h tgt=%h exp=0/0", out_res, branch_target);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] exp_res;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_res = XLEN'(i);
            send(exp_res, 5'd1, 4'b1000);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_res !== exp_res) begin
                miscompares++; $display("FAIL stream_%0d valid=%b res=%h exp=1/%h", i, out_valid, out_res, exp_res);
            end
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
        end
        idle_inputs();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(64'hA, 5'd2, 4'b1000);
        step();
        vectors++;
        if (out_res !== 64'hA || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_first res=%h rdy=%b exp=a/1", out_res, in_ready);
        end
        send(64'hB, 5'd3, 4'b1000);
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_res !== 64'hA) begin
            miscompares++; $display("FAIL bp_full rdy=%b res=%h exp=0/a", in_ready, out_res);
        end
        send(64'hC, 5'd4, 4'b1000);
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_res !== 64'hA || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_hold rdy=%b res=%h vld=%b exp=0/a/1", in_ready, out_res, out_valid);
        end
        // Pop in FULL: 0xC stays offered but cannot enter on this edge.
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_res !== 64'hB || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_pop_b res=%h rdy=%b exp=b/1", out_res, in_ready);
        end
        step();
        vectors++;
        if (out_res !== 64'hC || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_pop_c res=%h vld=%b exp=c/1", out_res, out_valid);
        end
        idle_inputs();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        send(64'h0, 5'd0, 4'b0000);
        in_branch = 1'b1;
        in_zero   = 1'b1;
        in_pc     = 64'h1000;
        in_imm    = 64'h10;
        step();
        vectors++;
        if (branch_taken !== 1'b1 || branch_target !== 64'h1020) begin
            miscompares++; $display("FAIL br_taken bt=%b tgt=%h exp=1/1020", branch_taken, branch_target);
        end
        idle_inputs();
        step();
        vectors++;
        if (branch_taken !== 1'b0) begin miscompares++; $display("FAIL br_pulse got=%b exp=0", branch_taken); end

        send(64'h0, 5'd0, 4'b0000);
        in_branch = 1'b1;
        in_zero   = 1'b0;
        in_pc     = 64'h1000;
        in_imm    = 64'h10;
        step();
        vectors++;
        if (branch_taken !== 1'b0) begin miscompares++; $display("FAIL br_not_taken got=%b exp=0", branch_taken); end

        in_zero = 1'b1;
        in_pc   = 64'hFFFF_FFFF_FFFF_FFF0;
        in_imm  = 64'h10;
        step();
        vectors++;
        if (branch_taken !== 1'b1 || branch_target !== 64'h10) begin
            miscompares++; $display("FAIL br_wrap bt=%b tgt=%h exp=1/10", branch_taken, branch_target);
        end

        in_pc  = 64'h1000;
        in_imm = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        vectors++;
        if (branch_taken !== 1'b1 || branch_target !== 64'hFFC) begin
            miscompares++; $display("FAIL br_negative bt=%b tgt=%h exp=1/ffc", branch_taken, branch_target);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(64'h11, 5'd5, 4'b1000);
        step();
        send(64'h22, 5'd6, 4'b1000);
        step();
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_setup_full got=%b exp=0", in_ready); end
        send(64'h99, 5'd7, 4'b1000);
        in_branch = 1'b1;
        in_zero   = 1'b1;
        in_pc     = 64'h2000;
        in_imm    = 64'h4;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || branch_taken !== 1'b0) begin
            miscompares++; $display("FAIL fl_full vld=%b rdy=%b bt=%b exp=0/1/0", out_valid, in_ready, branch_taken);
        end
        // Now in EMPTY: the branch would be accepted, but flush suppresses both it and its redirect.
        step();
        vectors++;
        if (out_valid !== 1'b0 || branch_taken !== 1'b0) begin
            miscompares++; $display("FAIL fl_branch vld=%b bt=%b exp=0/0", out_valid, branch_taken);
        end
        idle_inputs();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_gone got=%b exp=0", out_valid); end
        send(64'h33, 5'd8, 4'b1000);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_res !== 64'h33) begin
            miscompares++; $display("FAIL fl_recover vld=%b res=%h exp=1/33", out_valid, out_res);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_forwarding();
        out_ready = 1'b1;
        send(64'h55, 5'd7, 4'b1000);
        step();
        vectors++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 64'h55) begin
            miscompares++; $display("FAIL fwd_hit v=%b rd=%0d d=%h exp=1/7/55", fwd_valid, fwd_rd, fwd_data);
        end
        vectors++;
        if (out_ctrl !== 4'b1000 || out_rd !== 5'd7) begin
            miscompares++; $display("FAIL fwd_head ctrl=%b rd=%0d exp=1000/7", out_ctrl, out_rd);
        end
        send(64'h66, 5'd0, 4'b1000);
        step();
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_rd0 got=%b exp=0", fwd_valid); end
        send(64'h77, 5'd7, 4'b0110);
        step();
        vectors++;
        if (fwd_valid !== 1'b0 || out_ctrl !== 4'b0110) begin
            miscompares++; $display("FAIL fwd_nowrite v=%b ctrl=%b exp=0/0110", fwd_valid, out_ctrl);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(64'hDEAD, 5'd9, 4'b1001);
        in_store_data = 64'hBEEF;
        step();
        send(64'h0, 5'd0, 4'b0000);
        in_branch = 1'b1;
        in_zero   = 1'b1;
        in_pc     = 64'h4000;
        in_imm    = 64'h8;
        step();
        vectors++;
        if (branch_taken !== 1'b1 || branch_target !== 64'h4010 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rm_setup bt=%b tgt=%h rdy=%b exp=1/4010/0", branch_taken, branch_target, in_ready);
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || branch_taken !== 1'b0 || fwd_valid !== 1'b0) begin
            miscompares++; $display("FAIL rm_flags vld=%b rdy=%b bt=%b fwd=%b exp=0/1/0/0", out_valid, in_ready, branch_taken, fwd_valid);
        end
        vectors++;
        if (out_res !== 64'h0 || out_store_data !== 64'h0 || out_rd !== 5'd0 || out_ctrl !== 4'b0 || branch_target !== 64'h0) begin
            miscompares++; $display("FAIL rm_payload res=%h sd=%h rd=%0d ctrl=%b tgt=%h exp=all 0", out_res, out_store_data, out_rd, out_ctrl, branch_target);
        end
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_survivor got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_flush();
        test_forwarding();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage directly downstream of the 64-bit ALU: captures each ALU result with its zero flag, store data and write-back controls into a 2-entry skid buffer. Presents them to the memory stage through a valid/ready handshake. Resolves conditional branches (branch & zero) into a registered redirect pulse, and exposes the head entry for EX-stage forwarding.

## Interface
- XLEN, 64, datapath width (ALU result, store data, pc, imm)
- REGW, 5, register index width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream (ALU side) entry valid
- in_ready  output  1  stage can accept an entry this cycle
- in_res  input  XLEN  ALU result
- in_zero  input  1  ALU zero flag
- in_store_data  input  XLEN  rs2 value for stores
- in_rd  input  REGW  destination register
- in_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}
- in_branch  input  1  entry is a conditional branch (beq-style: taken when zero=1)
- in_pc  input  XLEN  pc of the instruction
- in_imm  input  XLEN  sign-extended branch offset in halfwords
- flush  input  1  discard all buffered entries and any same-cycle input
- out_valid  output  1  head entry valid to memory stage
- out_ready  input  1  memory stage consumes head
- out_res, out_store_data  output  XLEN each  head payload
- out_rd  output  REGW  head destination
- out_ctrl  output  4  head controls, same packing as in_ctrl
- branch_taken  output  1  one-cycle redirect pulse
- branch_target  output  XLEN  redirect pc, valid while branch_taken=1
- fwd_valid  output  1  head holds reg_write=1 and rd≠0
- fwd_rd  output  REGW  equals out_rd
- fwd_data  output  XLEN  equals out_res

## Operation
- Storage: 2 entries (head, tail); occupancy count ∈ {0,1,2} acts as the state: EMPTY, ONE, FULL.
- Payload stored per entry: res, store_data, rd, ctrl. zero, branch, pc and imm are consumed at acceptance and not stored.
- in_ready = (count != 2). Depends only on the register, so there is no combinational ready-to-ready path.
- Accept when in_valid & in_ready. Pop when out_valid & out_ready.
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL; pop only → EMPTY; accept+pop → ONE, with the new entry becoming head.
  - FULL: pop → ONE, with tail moving to head. No accept is possible in FULL, even with a same-cycle pop.
- out_valid = (count != 0). Head outputs are driven from registers and hold stable while out_valid & ~out_ready.
- Branch: on accept with in_branch=1 and in_zero=1, the next cycle has branch_taken=1 and branch_target = in_pc + {in_imm[XLEN-2:0],1'b0}. The add is modulo 2^XLEN and wraps silently.
- Branch entries are still buffered and popped like any other entry. Their ctrl is normally all-zero, and the stage does not alter it.
- fwd_valid = out_valid & out_ctrl[3] & (out_rd != 0).
- flush:
  - Next cycle count=0. Same-cycle accept is dropped and same-cycle pop is ignored.
  - branch_taken is forced to 0 in the next cycle.
  - flush takes priority over all other events.

## Timing
- Reset (async, immediate):
  - count=0, out_valid=0, in_ready=1, branch_taken=0, fwd_valid=0.
  - branch_target, out_res, out_store_data, out_rd and out_ctrl all read 0.
- Reset asserted mid-operation discards all entries. No partial entry survives.
- Latency: an entry accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1) when the stage was EMPTY, or when it was ONE and popped in the same cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- branch_taken: exactly one cycle, the cycle after acceptance. It is never repeated while the entry waits in the buffer.
- All outputs are registered or pure functions of registers. No input-to-output combinational path exists.

## Test plan
- **Reset mid-stream**: after 2 entries are accepted, pulse reset → out_valid=0, in_ready=1, and all out_* and branch_target read 0 on the same cycle.
- **Stream with out_ready=1**: send res=0x1, 0x2, 0x3 on consecutive cycles → out_res shows 0x1, 0x2, 0x3 on the following consecutive cycles, in_ready stays 1, count never exceeds 1.
- **Backpressure**:
  - With out_ready=0, send res=0xA, then 0xB → in_ready=0 after the second accept, head=0xA held stable.
  - A third in_valid (res=0xC) is not accepted until a pop.
  - Raising out_ready yields 0xA, 0xB, 0xC in order, with no loss or duplication.
- **Branch**:
  - Accept in_branch=1, in_zero=1, pc=0x1000, imm=0x10 → next cycle branch_taken=1, branch_target=0x1020, then 0.
  - The same entry with in_zero=0 → branch_taken stays 0.
  - pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x10 → target 0x0000_0000_0000_0010 (wrap).
- **Flush**: in FULL state, assert flush with in_valid=1 and out_ready=1 → next cycle out_valid=0, in_ready=1, and the flushed entries never appear. A pending branch_taken is suppressed.
- **Forwarding**:
  - Head with ctrl reg_write=1, rd=7, res=0x55 → fwd_valid=1, fwd_rd=7, fwd_data=0x55.
  - rd=0 or reg_write=0 → fwd_valid=0.
